// File: rtl/access_return_distributor.sv
// Return-path distributor: queues responses from a shared resource and
// presents the head to its requester, dropping it if unacknowledged too long.
module access_return_distributor #(
    parameter int switch_bits = 3,
    parameter int data_width  = 132,
    parameter int fifo_depth  = 4,
    parameter int timeout     = 15
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [switch_bits-1:0]          in_id,
    input  logic [data_width-1:0]           in_data,
    output logic                            in_ready,
    output logic [(1<<switch_bits)-1:0]     out_valid,
    output logic [data_width-1:0]           out_data,
    input  logic [(1<<switch_bits)-1:0]     out_ack,
    output logic                            drop,
    output logic [$clog2(fifo_depth):0]     count
);

    localparam int PW = $clog2(fifo_depth);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(timeout + 1);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t                 state;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [TW-1:0]          timer;
    logic [CW-1:0]          count_next;

    logic [switch_bits-1:0] id_mem   [fifo_depth];
    logic [data_width-1:0]  data_mem [fifo_depth];

    logic [switch_bits-1:0] head_id;
    logic [data_width-1:0]  head_data;
    logic                   push;
    logic                   ack_hit;
    logic                   expired;
    logic                   pop;

    assign head_id   = id_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // No full-queue bypass: a pop in the same cycle does not open a slot.
    assign in_ready = (count < CW'(fifo_depth));
    assign push     = in_valid && in_ready;
    assign ack_hit  = (state == PRESENT) && out_ack[head_id];
    // An ack in the timeout cycle wins over the discard.
    assign expired  = (state == PRESENT) && !ack_hit
                   && (timer == TW'(timeout));
    assign pop      = ack_hit || expired;

    // Occupancy after this edge's push and pop.
    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Control FSM: pointers, occupancy, wait timer and drop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            timer  <= '0;
            drop   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            drop  <= expired;
            state <= (count_next == '0) ? IDLE : PRESENT;
            if (pop || state == IDLE)
                timer <= '0;
            else
                timer <= timer + 1'b1;
        end
    end

    // Queue storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            id_mem[wr_ptr]   <= in_id;
            data_mem[wr_ptr] <= in_data;
        end
    end

    // Present the head on the shared bus with a one-hot strobe.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        if (state == PRESENT) begin
            out_valid[head_id] = 1'b1;
            out_data           = head_data;
        end
    end

endmodule

// File: tb/tb_access_return_distributor.sv
// Directed bench for access_return_distributor with hand-computed
// expectations for delivery, ordering, fill, timeout and reset.
module tb_access_return_distributor;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [2:0]   in_id;
    logic [131:0] in_data;
    logic         in_ready;
    logic [7:0]   out_valid;
    logic [131:0] out_data;
    logic [7:0]   out_ack;
    logic         drop;
    logic [2:0]   count;

    int n_chk  = 0;
    int n_pass = 0;

    access_return_distributor dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_id    (in_id),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ack  (out_ack),
        .drop     (drop),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [135:0] got,
                       input logic [135:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
    endtask

    // Advance one clock; outputs are stable 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_id    = '0;
        in_data  = '0;
        out_ack  = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_drop", drop, 0);

        // single response
        out_ack  = 8'hFF;
        in_valid = 1'b1;
        in_id    = 3'd5;
        in_data  = 132'hA5;
        step();
        in_valid = 1'b0;
        chk("single_valid", out_valid, 8'h20);
        chk("single_data", out_data, 132'hA5);
        chk("single_count", count, 1);
        step();
        chk("single_gone", out_valid, 0);
        chk("single_cnt0", count, 0);
        chk("single_drop", drop, 0);

        // fill past capacity with no acks
        out_ack = 8'h00;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fill_ready%0d", i), in_ready, (i < 4) ? 1 : 0);
            in_valid = 1'b1;
            in_id    = 3'(i);
            in_data  = 132'(32'h100 + i);
            step();
        end
        in_valid = 1'b0;
        chk("fill_count", count, 4);
        chk("fill_ready", in_ready, 0);
        // drain; offered entry while full must be refused
        out_ack = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_v%0d", i), out_valid, 8'(1 << i));
            chk($sformatf("drain_d%0d", i), out_data, 132'(32'h100 + i));
            if (i == 0) begin
                in_valid = 1'b1;
                in_id    = 3'd7;
                in_data  = 132'h77;
            end
            step();
            in_valid = 1'b0;
            if (i == 0)
                chk("full_nobypass", count, 3);
        end
        chk("drain_count", count, 0);
        chk("drain_valid", out_valid, 0);

        // ordering, back-to-back delivery
        out_ack = 8'hFF;
        in_valid = 1'b1;
        in_id = 3'd3; in_data = 132'h31;
        step();
        chk("ord_v0", out_valid, 8'h08);
        chk("ord_d0", out_data, 132'h31);
        in_id = 3'd1; in_data = 132'h12;
        step();
        chk("ord_v1", out_valid, 8'h02);
        chk("ord_d1", out_data, 132'h12);
        chk("ord_cnt1", count, 1);
        in_id = 3'd3; in_data = 132'h33;
        step();
        chk("ord_v2", out_valid, 8'h08);
        chk("ord_d2", out_data, 132'h33);
        in_valid = 1'b0;
        step();
        chk("ord_v3", out_valid, 0);
        chk("ord_cnt", count, 0);

        // timeout with a wrong-requester ack
        out_ack  = 8'h01;
        in_valid = 1'b1;
        in_id = 3'd2; in_data = 132'h22;
        step();
        in_id = 3'd6; in_data = 132'h66;
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("to_v%0d", k), out_valid, 8'h04);
            chk($sformatf("to_drop%0d", k), drop, 0);
            step();
            in_valid = 1'b0;
        end
        chk("to_drop", drop, 1);
        chk("to_count", count, 1);
        chk("to_next_v", out_valid, 8'h40);
        chk("to_next_d", out_data, 132'h66);
        out_ack = 8'hFF;
        step();
        chk("to_drop_end", drop, 0);
        chk("to_cnt0", count, 0);

        // ack arriving in the timeout cycle
        out_ack  = 8'h00;
        in_valid = 1'b1;
        in_id = 3'd2; in_data = 132'h2A;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 15; k++)
            step();
        chk("at_v16", out_valid, 8'h04);
        out_ack = 8'h04;
        step();
        chk("at_drop", drop, 0);
        chk("at_count", count, 0);
        chk("at_valid", out_valid, 0);
        step();
        chk("at_drop2", drop, 0);

        // reset mid-run
        out_ack  = 8'h00;
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_id   = 3'(i);
            in_data = 132'(i);
            step();
        end
        chk("mr_count3", count, 3);
        rst = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("mr_count", count, 0);
        chk("mr_valid", out_valid, 0);
        chk("mr_data", out_data, 0);
        chk("mr_drop", drop, 0);
        chk("mr_ready", in_ready, 1);
        step();
        chk("mr_drop2", drop, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
